// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  // Sequencer states: IDLE waits for start, RUN iterates, DONE flags completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Default operand width of the ALU divider.
  localparam int DIV_WIDTH = 4;

  // Iteration counter width for the default operand width.
  localparam int CNT_W = $clog2(DIV_WIDTH);

  // Quotient reported on divide-by-zero (all ones).
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  // Iteration counter width for an arbitrary operand width (at least one bit).
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// One trial subtraction of the restoring divider: shifted - {0, divisor}.
// Built as a ripple of full adders on the inverted divisor with carry-in 1;
// a missing carry-out means the subtraction borrowed.
module div_sub_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   diff,
  output logic             borrow
);

  logic [WIDTH:0]   divisor_n;
  logic [WIDTH+1:0] carry;

  assign divisor_n = ~{1'b0, divisor};
  assign carry[0]  = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    one_bit_full_adder u_fa (
      .a    (shifted[i]),
      .b    (divisor_n[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow = ~carry[WIDTH+1];

endmodule

// File: rtl/one_bit_full_adder.sv
// Single full-adder cell, shared with the ripple-carry add/subtract datapath.
module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/four_bit_seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
module four_bit_seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_reg, q_reg, div_reg;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] next_rem, next_q;
  logic             unused_trial_msb;

  // A new operation may start whenever the sequencer is not iterating.
  assign accept    = start && (state_q != RUN);
  assign last_iter = (cnt == LAST_CNT);

  assign shifted = {rem_reg, q_reg[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .shifted (shifted),
    .divisor (div_reg),
    .diff    (trial),
    .borrow  (borrow)
  );

  // Restore the partial remainder when the trial subtraction borrowed.
  assign next_rem = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign next_q   = {q_reg[WIDTH-2:0], ~borrow};
  // The trial MSB is always zero when no borrow occurs, so it is not needed.
  assign unused_trial_msb = trial[WIDTH];

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: zero divisor short-circuits straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (divisor == '0) ? DONE : RUN;
        else       state_d = IDLE;
      end
      RUN:     state_d = last_iter ? DONE : RUN;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in RUN, publish on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg     <= '0;
      q_reg       <= '0;
      div_reg     <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        quotient    <= ALL_ONES;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        rem_reg <= '0;
        q_reg   <= dividend;
        div_reg <= divisor;
        cnt     <= '0;
      end
    end else if (state_q == RUN) begin
      rem_reg <= next_rem;
      q_reg   <= next_q;
      cnt     <= cnt + 1'b1;
      if (last_iter) begin
        quotient    <= next_q;
        remainder   <= next_rem;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
